// File: rtl/valid_ready_fifo_pkg.sv
// Shared sizing helpers and pointer type for the valid/ready FIFO.
package valid_ready_fifo_pkg;

  localparam int VR_A_WIDTH = 2;

  function automatic int fifo_depth(input int a_width);
    return 1 << a_width;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int a_width);
    return a_width + 1;
  endfunction

  typedef logic [ptr_width(VR_A_WIDTH)-1:0] vr_ptr_t;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the FIFO: synchronous write, combinational read, no reset.
module fifo_regfile
  import valid_ready_fifo_pkg::*;
#(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2,
  parameter int DEPTH   = fifo_depth(A_WIDTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/valid_ready_fifo.sv
// Single-clock FIFO with valid/ready handshakes on both sides.
// Define VR_FIFO_LEVEL_EN to add the occupancy output 'level'.
module valid_ready_fifo
  import valid_ready_fifo_pkg::*;
#(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready
`ifdef VR_FIFO_LEVEL_EN
  ,
  output logic [A_WIDTH:0]   level
`endif
);

  localparam logic [A_WIDTH:0] PTR_ONE = 1;

  logic [A_WIDTH:0]   wr_ptr;
  logic [A_WIDTH:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [D_WIDTH-1:0] rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[A_WIDTH-1:0] == rd_ptr[A_WIDTH-1:0]) &&
                 (wr_ptr[A_WIDTH] != rd_ptr[A_WIDTH]);

  // Flags come only from registered pointers, so up_ready never sees down_ready.
  assign up_ready   = !full && !rst;
  assign down_valid = !empty && !rst;
  assign down_data  = rst ? '0 : rdata;

  assign push = up_valid && up_ready;
  assign pop  = down_valid && down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  fifo_regfile #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[A_WIDTH-1:0]),
    .wdata (up_data),
    .raddr (rd_ptr[A_WIDTH-1:0]),
    .rdata (rdata)
  );

`ifdef VR_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Scoreboard bench for valid_ready_fifo; a queue models FIFO contents.
module tb_valid_ready_fifo;

  localparam int D_WIDTH = 6;
  localparam int A_WIDTH = 2;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst;
  logic [D_WIDTH-1:0] up_data;
  logic               up_valid;
  logic               up_ready;
  logic [D_WIDTH-1:0] down_data;
  logic               down_valid;
  logic               down_ready;
`ifdef VR_FIFO_LEVEL_EN
  logic [A_WIDTH:0]   level;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [D_WIDTH-1:0] sb_q[$];

  valid_ready_fifo #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready)
`ifdef VR_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; compare against the model just before the edge, then
  // apply the handshakes the model says will happen at that edge.
  task automatic cycle(input logic uv, input logic [D_WIDTH-1:0] ud, input logic dr);
    logic exp_rdy;
    logic exp_vld;
    logic [D_WIDTH-1:0] exp_data;
    up_valid   = uv;
    up_data    = ud;
    down_ready = dr;
    @(negedge clk);
    exp_rdy = (sb_q.size() < DEPTH);
    exp_vld = (sb_q.size() > 0);
    chk("up_ready", {31'd0, up_ready}, {31'd0, exp_rdy});
    chk("down_valid", {31'd0, down_valid}, {31'd0, exp_vld});
`ifdef VR_FIFO_LEVEL_EN
    chk("level", {29'd0, level}, sb_q.size());
`endif
    if (exp_vld) begin
      exp_data = sb_q[0];
      chk("down_data", {26'd0, down_data}, {26'd0, exp_data});
      if (dr) void'(sb_q.pop_front());
    end
    if (uv && exp_rdy) sb_q.push_back(ud);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    #3;
    chk("rst_up_ready", {31'd0, up_ready}, 32'd0);
    chk("rst_down_valid", {31'd0, down_valid}, 32'd0);
    chk("rst_down_data", {26'd0, down_data}, 32'd0);
`ifdef VR_FIFO_LEVEL_EN
    chk("rst_level", {29'd0, level}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0);

    // Single word, latency and pop
    cycle(1'b1, 6'h2A, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Fill to full, refused fifth push, drain in order
    for (int i = 1; i <= 4; i++) cycle(1'b1, D_WIDTH'(i), 1'b0);
    cycle(1'b1, 6'h05, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Full with simultaneous offer and pop: no write-through
    for (int i = 1; i <= 4; i++) cycle(1'b1, D_WIDTH'(i), 1'b0);
    cycle(1'b1, 6'h3F, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Streaming across several pointer wraps
    for (int i = 0; i < 20; i++) cycle(1'b1, D_WIDTH'(i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Pops on an empty FIFO must not move the read pointer
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 6'h15, 1'b0);
    cycle(1'b1, 6'h16, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Reset mid-stream with two words stored
    cycle(1'b1, 6'h0A, 1'b0);
    cycle(1'b1, 6'h0B, 1'b0);
    up_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mid_rst_up_ready", {31'd0, up_ready}, 32'd0);
    chk("mid_rst_down_valid", {31'd0, down_valid}, 32'd0);
    chk("mid_rst_down_data", {26'd0, down_data}, 32'd0);
`ifdef VR_FIFO_LEVEL_EN
    chk("mid_rst_level", {29'd0, level}, 32'd0);
`endif
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 6'h33, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
